// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, states,
// ALU operations, datapath select values and latched qualifiers.
// Optional jal support is enabled with MC_CTRL_JAL_EN.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_LHU   = 6'b100101;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SH    = 6'b101001;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_R_WB      = 4'd7,
      S_EXEC_I    = 4'd8,
      S_I_WB      = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11,
      S_ERR       = 4'd12
   } state_e;

   localparam logic [2:0] ALU_AND   = 3'b000;
   localparam logic [2:0] ALU_OR    = 3'b001;
   localparam logic [2:0] ALU_ADD   = 3'b011;
   localparam logic [2:0] ALU_SUB   = 3'b100;
   localparam logic [2:0] ALU_SLT   = 3'b101;
   localparam logic [2:0] ALU_FUNCT = 3'b111;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   typedef enum logic [2:0] {
      C_RTYPE, C_MEM, C_IMM, C_BRANCH, C_JUMP, C_ILLEGAL
   } iclass_e;

   typedef struct packed {
      logic       branch;
      logic       branch_not;
      logic       unsign;
      logic       lbu;
      logic       lhu;
      logic       sb;
      logic       sh;
      logic       lui;
      logic       jal;
      logic       is_store;
      logic [2:0] alu_op_i;
   } qual_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Opcode/handshake inputs and control outputs of the multicycle FSM.
interface mc_control_fsm_if #(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 3
);
   logic [OPCODE_W-1:0] opcode;
   logic                mem_ready;
   logic                ir_wr, pc_wr, mem_rd, mem_wr, reg_wr;
   logic                reg_dst, mem_to_reg, alu_src_a;
   logic [1:0]          alu_src_b, pc_src;
   logic [ALUOP_W-1:0]  alu_op;
   logic                branch, branch_not, unsign, lbu, lhu, sb, sh, lui, jal;
   logic                instr_done, err;
   logic [3:0]          state_o;

   modport master (
      output opcode, mem_ready,
      input  ir_wr, pc_wr, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg, alu_src_a,
      input  alu_src_b, pc_src, alu_op,
      input  branch, branch_not, unsign, lbu, lhu, sb, sh, lui, jal,
      input  instr_done, err, state_o
   );

   modport slave (
      input  opcode, mem_ready,
      output ir_wr, pc_wr, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg, alu_src_a,
      output alu_src_b, pc_src, alu_op,
      output branch, branch_not, unsign, lbu, lhu, sb, sh, lui, jal,
      output instr_done, err, state_o
   );
endinterface

// File: rtl/mc_control_fsm_decode.sv
// Opcode to instruction class and qualifier decode (combinational).
// Opcode 000011 is decoded as jal only when MC_CTRL_JAL_EN is defined.
module mc_opcode_decode
   import mc_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6
) (
   input  logic [OPCODE_W-1:0] opcode,
   output iclass_e             iclass,
   output qual_t               qual
);

   // classify the opcode and derive the per-instruction qualifiers
   always_comb begin
      iclass = C_ILLEGAL;
      qual   = '0;
      case (opcode)
         OPCODE_W'(OP_RTYPE): iclass = C_RTYPE;
         OPCODE_W'(OP_LW):    iclass = C_MEM;
         OPCODE_W'(OP_LBU):   begin iclass = C_MEM; qual.lbu = 1'b1; qual.unsign = 1'b1; end
         OPCODE_W'(OP_LHU):   begin iclass = C_MEM; qual.lhu = 1'b1; qual.unsign = 1'b1; end
         OPCODE_W'(OP_SW):    begin iclass = C_MEM; qual.is_store = 1'b1; end
         OPCODE_W'(OP_SB):    begin iclass = C_MEM; qual.is_store = 1'b1; qual.sb = 1'b1; end
         OPCODE_W'(OP_SH):    begin iclass = C_MEM; qual.is_store = 1'b1; qual.sh = 1'b1; end
         OPCODE_W'(OP_ADDI):  begin iclass = C_IMM; qual.alu_op_i = ALU_ADD; end
         OPCODE_W'(OP_ADDIU): begin iclass = C_IMM; qual.alu_op_i = ALU_ADD; qual.unsign = 1'b1; end
         OPCODE_W'(OP_ANDI):  begin iclass = C_IMM; qual.alu_op_i = ALU_AND; end
         OPCODE_W'(OP_ORI):   begin iclass = C_IMM; qual.alu_op_i = ALU_OR; end
         OPCODE_W'(OP_SLTI):  begin iclass = C_IMM; qual.alu_op_i = ALU_SLT; end
         OPCODE_W'(OP_SLTIU): begin iclass = C_IMM; qual.alu_op_i = ALU_SLT; qual.unsign = 1'b1; end
         OPCODE_W'(OP_LUI):   begin iclass = C_IMM; qual.alu_op_i = ALU_ADD; qual.lui = 1'b1; end
         OPCODE_W'(OP_BEQ):   begin iclass = C_BRANCH; qual.branch = 1'b1; end
         OPCODE_W'(OP_BNE):   begin iclass = C_BRANCH; qual.branch_not = 1'b1; end
         OPCODE_W'(OP_J):     iclass = C_JUMP;
`ifdef MC_CTRL_JAL_EN
         OPCODE_W'(OP_JAL):   begin iclass = C_JUMP; qual.jal = 1'b1; end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle processor control FSM: Moore strobes from the registered state,
// memory wait counter with timeout to a sticky error state.
// Define MC_CTRL_JAL_EN to accept opcode 000011 (jal) as a linking jump.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int OPCODE_W    = 6,
   parameter int ALUOP_W     = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input logic              clk,
   input logic              rst,
   mc_control_fsm_if.slave  bus
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   qual_t            qual_q, qual_d;
   iclass_e          dec_class;
   qual_t            dec_qual;
   logic             wait_st;
   logic             timeout;
   logic [2:0]       aop;

   mc_opcode_decode #(.OPCODE_W(OPCODE_W)) u_decode (
      .opcode (bus.opcode),
      .iclass (dec_class),
      .qual   (dec_qual)
   );

   // state, wait counter and qualifier registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         qual_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         qual_q  <= qual_d;
      end
   end

   // next state; counter is zero outside the wait states so every entry starts clean
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      qual_d  = qual_q;
      timeout = 1'b0;
      wait_st = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
      if (wait_st && !bus.mem_ready) begin
         cnt_d   = cnt_q + 1'b1;
         timeout = (cnt_d == CNT_W'(MEM_TIMEOUT));
      end
      case (state_q)
         S_FETCH: begin
            if (bus.mem_ready)  state_d = S_DECODE;
            else if (timeout)   state_d = S_ERR;
         end
         S_DECODE: begin
            qual_d = dec_qual;
            case (dec_class)
               C_RTYPE:  state_d = S_EXEC_R;
               C_MEM:    state_d = S_MEM_ADDR;
               C_IMM:    state_d = S_EXEC_I;
               C_BRANCH: state_d = S_BRANCH;
               C_JUMP:   state_d = S_JUMP;
               default:  state_d = S_ERR;
            endcase
         end
         S_MEM_ADDR:  state_d = qual_q.is_store ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ: begin
            if (bus.mem_ready)  state_d = S_MEM_WB;
            else if (timeout)   state_d = S_ERR;
         end
         S_MEM_WRITE: begin
            if (bus.mem_ready)  state_d = S_FETCH;
            else if (timeout)   state_d = S_ERR;
         end
         S_EXEC_R:    state_d = S_R_WB;
         S_EXEC_I:    state_d = S_I_WB;
         S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
         S_ERR:       state_d = S_ERR;
         default:     state_d = S_ERR;
      endcase
      // qualifiers live for one instruction; drop them as it retires
      if (state_d == S_FETCH && state_q != S_FETCH) qual_d = '0;
   end

   // Moore strobes; only FETCH ir_wr/pc_wr and the store retire pulse look at mem_ready
   always_comb begin
      bus.ir_wr      = 1'b0;
      bus.pc_wr      = 1'b0;
      bus.mem_rd     = 1'b0;
      bus.mem_wr     = 1'b0;
      bus.reg_wr     = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = SRCB_REG;
      bus.pc_src     = PC_ALU;
      bus.instr_done = 1'b0;
      bus.err        = 1'b0;
      aop            = ALU_AND;
      case (state_q)
         S_FETCH: begin
            bus.mem_rd    = 1'b1;
            bus.alu_src_b = SRCB_FOUR;
            aop           = ALU_ADD;
            bus.ir_wr     = bus.mem_ready;
            bus.pc_wr     = bus.mem_ready;
         end
         S_DECODE: begin
            bus.alu_src_b = SRCB_IMM_SH;
            aop           = ALU_ADD;
         end
         S_MEM_ADDR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = SRCB_IMM;
            aop           = ALU_ADD;
         end
         S_MEM_READ:  bus.mem_rd = 1'b1;
         S_MEM_WRITE: begin
            bus.mem_wr     = 1'b1;
            bus.instr_done = bus.mem_ready;
         end
         S_MEM_WB: begin
            bus.reg_wr     = 1'b1;
            bus.mem_to_reg = 1'b1;
            bus.instr_done = 1'b1;
         end
         S_EXEC_R: begin
            aop         = ALU_FUNCT;
            bus.reg_dst = 1'b1;
         end
         S_R_WB: begin
            aop            = ALU_FUNCT;
            bus.reg_dst    = 1'b1;
            bus.reg_wr     = 1'b1;
            bus.instr_done = 1'b1;
         end
         S_EXEC_I: begin
            bus.alu_src_b = SRCB_IMM;
            aop           = qual_q.alu_op_i;
         end
         S_I_WB: begin
            bus.alu_src_b  = SRCB_IMM;
            aop            = qual_q.alu_op_i;
            bus.reg_wr     = 1'b1;
            bus.instr_done = 1'b1;
         end
         S_BRANCH: begin
            aop            = ALU_SUB;
            bus.pc_src     = PC_ALUOUT;
            bus.instr_done = 1'b1;
         end
         S_JUMP: begin
            bus.pc_src     = PC_JUMP;
            bus.pc_wr      = 1'b1;
            bus.reg_wr     = qual_q.jal;
            bus.instr_done = 1'b1;
         end
         S_ERR:   bus.err = 1'b1;
         default: bus.err = 1'b1;
      endcase
      bus.alu_op = ALUOP_W'(aop);
   end

   assign bus.state_o    = state_q;
   assign bus.branch     = qual_q.branch;
   assign bus.branch_not = qual_q.branch_not;
   assign bus.unsign     = qual_q.unsign;
   assign bus.lbu        = qual_q.lbu;
   assign bus.lhu        = qual_q.lhu;
   assign bus.sb         = qual_q.sb;
   assign bus.sh         = qual_q.sh;
   assign bus.lui        = qual_q.lui;
`ifdef MC_CTRL_JAL_EN
   assign bus.jal        = qual_q.jal;
`else
   assign bus.jal        = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm; jal expectations follow MC_CTRL_JAL_EN.
module tb_mc_control_fsm;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   mc_control_fsm_if #(.OPCODE_W(6), .ALUOP_W(3)) bus ();

   mc_control_fsm #(.OPCODE_W(6), .ALUOP_W(3), .MEM_TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // strb = {ir_wr,pc_wr,mem_rd,mem_wr,reg_wr}
   // qual = {branch,branch_not,unsign,lbu,lhu,sb,sh,lui,jal}
   // mux  = {reg_dst,mem_to_reg,alu_src_a}; -1 = not checked
   typedef struct {
      string name;
      int    cyc;
      int    st, strb, done, err, aop, srcb, pcs, qual, mux;
   } exp_t;

   exp_t q[$];

   task automatic drv(input logic r, input logic [5:0] op, input logic rdy);
      @(posedge clk);
      #1;
      rst           = r;
      bus.opcode    = op;
      bus.mem_ready = rdy;
   endtask

   task automatic ex(input string name, input int st, input int strb, input int done,
                     input int err, input int aop = -1, input int srcb = -1,
                     input int pcs = -1, input int qual = -1, input int mux = -1);
      exp_t e;
      e.name = name; e.cyc = cyc; e.st = st; e.strb = strb; e.done = done; e.err = err;
      e.aop = aop; e.srcb = srcb; e.pcs = pcs; e.qual = qual; e.mux = mux;
      q.push_back(e);
   endtask

   // monitor: compare every expectation tagged for the current cycle
   always @(negedge clk) begin : mon
      exp_t e;
      int a_strb, a_qual, a_mux, a_aop, a_srcb, a_pcs, a_st, a_done, a_err;
      bit bad;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e      = q.pop_front();
         a_st   = int'(bus.state_o);
         a_strb = int'({bus.ir_wr, bus.pc_wr, bus.mem_rd, bus.mem_wr, bus.reg_wr});
         a_qual = int'({bus.branch, bus.branch_not, bus.unsign, bus.lbu, bus.lhu,
                        bus.sb, bus.sh, bus.lui, bus.jal});
         a_mux  = int'({bus.reg_dst, bus.mem_to_reg, bus.alu_src_a});
         a_aop  = int'(bus.alu_op);
         a_srcb = int'(bus.alu_src_b);
         a_pcs  = int'(bus.pc_src);
         a_done = int'(bus.instr_done);
         a_err  = int'(bus.err);
         bad = (e.cyc != cyc) || (a_st != e.st) || (a_strb != e.strb) ||
               (a_done != e.done) || (a_err != e.err) ||
               (e.aop >= 0 && a_aop != e.aop) || (e.srcb >= 0 && a_srcb != e.srcb) ||
               (e.pcs >= 0 && a_pcs != e.pcs) || (e.qual >= 0 && a_qual != e.qual) ||
               (e.mux >= 0 && a_mux != e.mux);
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL %s cyc=%0d/%0d got st=%0d strb=%05b done=%0d err=%0d aop=%0d srcb=%0d pcs=%0d qual=%09b mux=%03b want st=%0d strb=%05b done=%0d err=%0d aop=%0d srcb=%0d pcs=%0d qual=%0d mux=%0d",
                     e.name, cyc, e.cyc, a_st, a_strb[4:0], a_done, a_err, a_aop, a_srcb, a_pcs,
                     a_qual[8:0], a_mux[2:0], e.st, e.strb, e.done, e.err, e.aop, e.srcb,
                     e.pcs, e.qual, e.mux);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d required finish", cyc);
      $fatal(1);
   end

   initial begin
      bus.opcode    = '0;
      bus.mem_ready = 1'b0;
      drv(1, 6'b000000, 0);
      drv(0, 6'b000000, 0); ex("reset", 0, 5'b00100, 0, 0, 3, 1, 0, 0, 0);

      // add: 0,1,6,7,0
      drv(0, 6'b000000, 1); ex("add_fetch", 0, 5'b11100, 0, 0, 3, 1);
      drv(0, 6'b000000, 0); ex("add_decode", 1, 5'b00000, 0, 0, 3, 3);
      drv(0, 6'b000000, 0); ex("add_exec", 6, 5'b00000, 0, 0, 7, -1, -1, -1, 3'b100);
      drv(0, 6'b000000, 0); ex("add_wb", 7, 5'b00001, 1, 0, 7, -1, -1, -1, 3'b100);
      drv(0, 6'b000000, 0); ex("add_back", 0, 5'b00100, 0, 0);

      // lw with mem_ready late by 3 cycles
      drv(0, 6'b000000, 1); ex("lw_fetch", 0, 5'b11100, 0, 0);
      drv(0, 6'b100011, 0); ex("lw_decode", 1, 5'b00000, 0, 0);
      drv(0, 6'b000000, 0); ex("lw_addr", 2, 5'b00000, 0, 0, 3, 2, -1, 0, 3'b001);
      for (int i = 0; i < 3; i++) begin
         drv(0, 6'b000000, 0); ex("lw_wait", 3, 5'b00100, 0, 0);
      end
      drv(0, 6'b000000, 1); ex("lw_read_ok", 3, 5'b00100, 0, 0);
      drv(0, 6'b000000, 0); ex("lw_wb", 4, 5'b00001, 1, 0, -1, -1, -1, -1, 3'b010);
      drv(0, 6'b000000, 0); ex("lw_back", 0, 5'b00100, 0, 0, -1, -1, -1, 0);

      // sltiu: unsigned compare immediate
      drv(0, 6'b000000, 1);
      drv(0, 6'b001011, 0);
      drv(0, 6'b000000, 0); ex("sltiu_exec", 8, 5'b00000, 0, 0, 5, 2, -1, 9'b001000000);
      drv(0, 6'b000000, 0); ex("sltiu_wb", 9, 5'b00001, 1, 0, 5, 2, -1, 9'b001000000);

      // bne
      drv(0, 6'b000000, 1);
      drv(0, 6'b000101, 0);
      drv(0, 6'b000000, 0); ex("bne_branch", 10, 5'b00000, 1, 0, 4, -1, 1, 9'b010000000);
      drv(0, 6'b000000, 0); ex("bne_back", 0, 5'b00100, 0, 0, -1, -1, -1, 0);

      // j
      drv(0, 6'b000000, 1);
      drv(0, 6'b000010, 0);
      drv(0, 6'b000000, 0); ex("j_jump", 11, 5'b01000, 1, 0, -1, -1, 2, 0);

      // sh stalled in MEM_WRITE, then reset mid-instruction
      drv(0, 6'b000000, 1);
      drv(0, 6'b101001, 0);
      drv(0, 6'b000000, 0);
      drv(0, 6'b000000, 0); ex("sh_write", 5, 5'b00010, 0, 0, -1, -1, -1, 9'b000000100);
      drv(1, 6'b000000, 0); ex("sh_write_rst", 5, 5'b00010, 0, 0);
      drv(0, 6'b000000, 0); ex("rst_mid", 0, 5'b00100, 0, 0, -1, -1, -1, 0);

      // sw completing on first MEM_WRITE cycle
      drv(0, 6'b000000, 1);
      drv(0, 6'b101011, 0);
      drv(0, 6'b000000, 0);
      drv(0, 6'b000000, 1); ex("sw_write_done", 5, 5'b00010, 1, 0);
      drv(0, 6'b000000, 0); ex("sw_back", 0, 5'b00100, 0, 0);

      // illegal opcode: sticky ERR until rst
      drv(0, 6'b000000, 1);
      drv(0, 6'b111111, 0);
      drv(0, 6'b000000, 1); ex("illegal_err", 12, 5'b00000, 0, 1);
      drv(0, 6'b000000, 1); ex("err_sticky", 12, 5'b00000, 0, 1);
      drv(1, 6'b000000, 0); ex("err_sticky2", 12, 5'b00000, 0, 1);
      drv(0, 6'b000000, 0); ex("err_cleared", 0, 5'b00100, 0, 0);

      // jal
      drv(0, 6'b000000, 1);
      drv(0, 6'b000011, 0);
      drv(0, 6'b000000, 1);
`ifdef MC_CTRL_JAL_EN
      ex("jal_jump", 11, 5'b01001, 1, 0, -1, -1, 2, 9'b000000001);
      drv(0, 6'b000000, 0);
`else
      ex("jal_err", 12, 5'b00000, 0, 1, -1, -1, -1, 0);
      drv(1, 6'b000000, 0);
      drv(0, 6'b000000, 0);
`endif
      ex("jal_back", 0, 5'b00100, 0, 0, -1, -1, -1, 0);

      // mem_ready on the 15th waiting cycle still succeeds
      for (int i = 2; i <= 14; i++) drv(0, 6'b000000, 0);
      drv(0, 6'b000000, 1); ex("to_edge_ok", 0, 5'b11100, 0, 0);
      drv(0, 6'b000010, 0); ex("to_edge_decode", 1, 5'b00000, 0, 0);
      drv(0, 6'b000000, 0);

      // 15 cycles without mem_ready in FETCH -> ERR
      for (int i = 1; i <= 15; i++) begin
         drv(0, 6'b000000, 0);
         if (i == 1 || i == 15) ex("to_fetch", 0, 5'b00100, 0, 0);
      end
      drv(0, 6'b000000, 1); ex("timeout_err", 12, 5'b00000, 0, 1);
      drv(0, 6'b000000, 1); ex("timeout_sticky", 12, 5'b00000, 0, 1);
      drv(1, 6'b000000, 0);
      drv(0, 6'b000000, 0); ex("final_reset", 0, 5'b00100, 0, 0);

      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
